// File: rtl/ibex_pkg.sv
// Shared types for the shadow-stack control-flow monitor.
package ibex_pkg;

   // Major opcodes of the uncompressed instruction forms the monitor decodes
   typedef enum logic [6:0] {
      OPCODE_JALR = 7'h67,
      OPCODE_JAL  = 7'h6f
   } opcode_e;

   // Shadow-stack operation carried by a queue entry
   typedef enum logic {
      SS_PUSH = 1'b0,
      SS_POP  = 1'b1
   } ss_op_e;

   // Pending operation: target stack address plus the pc of the originating instruction
   typedef struct packed {
      ss_op_e      op;
      logic [31:0] addr;
      logic [31:0] pc;
   } ss_entry_t;

   // Sticky fault cause reported to software
   typedef enum logic [1:0] {
      SS_FAULT_NONE     = 2'b00,
      SS_FAULT_OVERFLOW = 2'b01,
      SS_FAULT_MISMATCH = 2'b10
   } ss_fault_e;

   localparam logic [4:0] REG_RA = 5'd1;
   localparam logic [4:0] REG_T0 = 5'd5;

endpackage

// File: rtl/ibex_ss_fifo.sv
// Pending shadow-stack op queue: up to two writes and one read per cycle.
// Port a is always written before port b when both are active.
module ibex_ss_fifo
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     wr_a_i,
   input  ss_entry_t                wdata_a_i,
   input  logic                     wr_b_i,
   input  ss_entry_t                wdata_b_i,
   input  logic                     rd_i,
   output ss_entry_t                rdata_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   ss_entry_t       mem [Depth];
   logic [PtrW-1:0] wptr;
   logic [PtrW-1:0] rptr;
   logic [CntW-1:0] count;

   // Storage: entry b lands one slot after entry a when both are written
   always_ff @(posedge clk_i) begin
      if (!flush_i) begin
         if (wr_a_i) mem[wptr] <= wdata_a_i;
         if (wr_b_i) mem[wptr + PtrW'(wr_a_i)] <= wdata_b_i;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since Depth is a power of 2
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + PtrW'(wr_a_i) + PtrW'(wr_b_i);
         rptr  <= rptr + PtrW'(rd_i);
         count <= count + CntW'(wr_a_i) + CntW'(wr_b_i) - CntW'(rd_i);
      end
   end

   assign rdata_o = mem[rptr];
   assign empty_o = (count == '0);
   assign count_o = count;

endmodule

// File: rtl/ibex_ss_cflow_monitor.sv
// Control-flow monitor: turns retiring calls/returns into shadow-stack push/pop ops.
//
// state    | meaning
// ST_RUN   | accepting instructions, issuing queued ops one per cycle
// ST_FAULT | sticky fault raised; no issue, no accept, queue held until clear_i
module ibex_ss_cflow_monitor
   import ibex_pkg::*;
#(
   parameter int unsigned QueueDepth = 4,
   parameter bit          AltLinkEn  = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_is_compressed_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] jump_target_i,
   output logic [31:0] ss_pointer_wr_o,
   output logic [31:0] ss_pointer_rd_o,
   output logic        ss_write_o,
   output logic        ss_read_o,
   input  logic        ss_error_i,
   output logic        alert_o,
   output logic [31:0] fault_pc_o,
   output logic [1:0]  fault_cause_o,
   input  logic        clear_i
);

   localparam int unsigned CntW = $clog2(QueueDepth) + 1;

   typedef enum logic {ST_RUN, ST_FAULT} state_e;

   state_e          state_q;
   logic            alert_q;
   logic [31:0]     fault_pc_q;
   ss_fault_e       cause_q;

   logic            wr_a, wr_b;
   ss_entry_t       ent_a, ent_b;
   ss_entry_t       head;
   logic            empty;
   logic [CntW-1:0] count;
   logic            accept, issue, deq, flush;

   logic [4:0]      rd, rs1;
   logic            rd_link, rs1_link, is_jal, is_jalr;
   logic [31:0]     link_addr;
   ss_entry_t       push_ent, pop_ent;
   logic            unused_instr;

   function automatic logic is_link(input logic [4:0] r);
      return (r == REG_RA) || (AltLinkEn && (r == REG_T0));
   endfunction

   assign rd        = instr_rdata_i[11:7];
   assign rs1       = instr_rdata_i[19:15];
   assign rd_link   = is_link(rd);
   assign rs1_link  = is_link(rs1);
   assign is_jal    = (instr_rdata_i[6:0] == OPCODE_JAL);
   assign is_jalr   = (instr_rdata_i[6:0] == OPCODE_JALR) && (instr_rdata_i[14:12] == 3'b000);
   assign link_addr = pc_i + (instr_is_compressed_i ? 32'd2 : 32'd4);
   assign push_ent  = '{op: SS_PUSH, addr: link_addr, pc: pc_i};
   assign pop_ent   = '{op: SS_POP, addr: jump_target_i, pc: pc_i};
   assign unused_instr = ^instr_rdata_i[31:20];

   // Ready only from the registered occupancy, so a same-cycle dequeue never earns credit
   assign instr_ready_o = (state_q == ST_RUN) && ((CntW'(QueueDepth) - count) >= CntW'(2));
   assign accept        = instr_valid_i && instr_ready_o;

   // Classify the retiring instruction into zero, one or two queue entries
   always_comb begin
      wr_a  = 1'b0;
      wr_b  = 1'b0;
      ent_a = push_ent;
      ent_b = push_ent;
      if (accept) begin
         if (is_jal && rd_link) begin
            wr_a = 1'b1;
         end else if (is_jalr) begin
            if (rd_link && !rs1_link) begin
               wr_a = 1'b1;
            end else if (!rd_link && rs1_link) begin
               wr_a  = 1'b1;
               ent_a = pop_ent;
            end else if (rd_link && rs1_link && (rd == rs1)) begin
               wr_a = 1'b1;
            end else if (rd_link && rs1_link) begin
               // Coroutine swap: return through rs1, then call with rd
               wr_a  = 1'b1;
               ent_a = pop_ent;
               wr_b  = 1'b1;
            end
         end
      end
   end

   // An erroring op stays at the head so the faulting state can be inspected
   assign issue = (state_q == ST_RUN) && !empty;
   assign deq   = issue && !ss_error_i;
   assign flush = (state_q == ST_FAULT) && clear_i;

   ibex_ss_fifo #(
      .Depth (QueueDepth)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (flush),
      .wr_a_i    (wr_a),
      .wdata_a_i (ent_a),
      .wr_b_i    (wr_b),
      .wdata_b_i (ent_b),
      .rd_i      (deq),
      .rdata_o   (head),
      .empty_o   (empty),
      .count_o   (count)
   );

   assign ss_write_o      = issue && (head.op == SS_PUSH);
   assign ss_read_o       = issue && (head.op == SS_POP);
   assign ss_pointer_wr_o = ss_write_o ? head.addr : 32'h0;
   assign ss_pointer_rd_o = ss_read_o  ? head.addr : 32'h0;

   // Run/fault sequencing with the sticky fault report
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_RUN;
         alert_q    <= 1'b0;
         fault_pc_q <= 32'h0;
         cause_q    <= SS_FAULT_NONE;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (issue && ss_error_i) begin
                  state_q    <= ST_FAULT;
                  alert_q    <= 1'b1;
                  fault_pc_q <= head.pc;
                  cause_q    <= (head.op == SS_PUSH) ? SS_FAULT_OVERFLOW : SS_FAULT_MISMATCH;
               end
            end
            ST_FAULT: begin
               if (clear_i) begin
                  state_q <= ST_RUN;
                  alert_q <= 1'b0;
                  cause_q <= SS_FAULT_NONE;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign alert_o       = alert_q;
   assign fault_pc_o    = fault_pc_q;
   assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_ibex_ss_cflow_monitor.sv
// Directed bench for ibex_ss_cflow_monitor with an expected-op scoreboard.
module tb_ibex_ss_cflow_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_rdata;
   logic        instr_comp;
   logic [31:0] pc_in;
   logic [31:0] jump_target;
   logic [31:0] ptr_wr, ptr_rd;
   logic        ss_write, ss_read;
   logic        ss_error;
   logic        alert;
   logic [31:0] fault_pc;
   logic [1:0]  fault_cause;
   logic        clear;

   typedef struct packed {
      logic        is_pop;
      logic [31:0] addr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   ibex_ss_cflow_monitor #(
      .QueueDepth (4),
      .AltLinkEn  (1'b1)
   ) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .instr_valid_i         (instr_valid),
      .instr_ready_o         (instr_ready),
      .instr_rdata_i         (instr_rdata),
      .instr_is_compressed_i (instr_comp),
      .pc_i                  (pc_in),
      .jump_target_i         (jump_target),
      .ss_pointer_wr_o       (ptr_wr),
      .ss_pointer_rd_o       (ptr_rd),
      .ss_write_o            (ss_write),
      .ss_read_o             (ss_read),
      .ss_error_i            (ss_error),
      .alert_o               (alert),
      .fault_pc_o            (fault_pc),
      .fault_cause_o         (fault_cause),
      .clear_i               (clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_jal(input logic [4:0] rd);
      return {20'h0, rd, 7'h6f};
   endfunction

   function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h0, rs1, 3'b000, rd, 7'h67};
   endfunction

   function automatic exp_t e_push(input logic [31:0] a);
      return '{is_pop: 1'b0, addr: a};
   endfunction

   function automatic exp_t e_pop(input logic [31:0] a);
      return '{is_pop: 1'b1, addr: a};
   endfunction

   // Every issued op is matched against the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         chk("one_strobe", 32'(ss_write & ss_read), 32'h0);
         if (ss_write || ss_read) begin
            if (sb.size() == 0) begin
               chk("unexpected_op", {30'h0, ss_write, ss_read}, 32'h0);
            end else begin
               e = sb.pop_front();
               chk("op_kind", 32'(ss_read), 32'(e.is_pop));
               chk("op_addr", ss_read ? ptr_rd : ptr_wr, e.addr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'h1);
   endtask

   task automatic drive(input logic [31:0] ins, input logic comp,
                        input logic [31:0] pc, input logic [31:0] tgt);
      instr_rdata = ins;
      instr_comp  = comp;
      pc_in       = pc;
      jump_target = tgt;
      instr_valid = 1'b1;
   endtask

   task automatic send(input logic [31:0] ins, input logic comp,
                       input logic [31:0] pc, input logic [31:0] tgt);
      wait_ready();
      drive(ins, comp, pc, tgt);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; instr_rdata = 32'h0; instr_comp = 1'b0;
      pc_in = 32'h0; jump_target = 32'h0; ss_error = 1'b0; clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(instr_ready), 32'h1);
      chk("rst_alert", 32'(alert), 32'h0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      chk("rst_cause", 32'(fault_cause), 32'h0);
      chk("rst_write", 32'(ss_write), 32'h0);
      chk("rst_read", 32'(ss_read), 32'h0);
      chk("rst_ptr_wr", ptr_wr, 32'h0);
      idle(1);

      // JAL x1 at 0x100: push 0x104 the cycle after acceptance
      sb.push_back(e_push(32'h104));
      send(enc_jal(5'd1), 1'b0, 32'h100, 32'h0);
      @(negedge clk);
      chk("jal_latency", 32'(ss_write), 32'h1);
      chk("jal_ptr", ptr_wr, 32'h104);
      idle(2);

      // c.jalr call then matching return
      sb.push_back(e_push(32'h202));
      send(enc_jalr(5'd1, 5'd10), 1'b1, 32'h200, 32'h1234);
      sb.push_back(e_pop(32'h202));
      send(enc_jalr(5'd0, 5'd1), 1'b0, 32'h210, 32'h202);
      idle(3);
      chk("callret_alert", 32'(alert), 32'h0);

      // JALR x5,0(x1): pop first, push next cycle
      sb.push_back(e_pop(32'h400));
      sb.push_back(e_push(32'h304));
      send(enc_jalr(5'd5, 5'd1), 1'b0, 32'h300, 32'h400);
      @(negedge clk);
      chk("swap_pop_first", 32'(ss_read), 32'h1);
      chk("swap_pop_ptr", ptr_rd, 32'h400);
      @(negedge clk);
      chk("swap_push_second", 32'(ss_write), 32'h1);
      chk("swap_push_ptr", ptr_wr, 32'h304);
      idle(2);

      // Assorted classifications, including wrap-around and non-link cases
      sb.push_back(e_push(32'h0));
      send(enc_jal(5'd1), 1'b0, 32'hFFFF_FFFC, 32'h0);
      sb.push_back(e_push(32'h200));
      send(enc_jal(5'd1), 1'b1, 32'h1FE, 32'h0);
      sb.push_back(e_push(32'h704));
      send(enc_jalr(5'd5, 5'd5), 1'b0, 32'h700, 32'h9000);
      send(enc_jal(5'd0), 1'b0, 32'h800, 32'h0);
      send({12'h0, 5'd1, 3'd0, 5'd1, 7'h13}, 1'b0, 32'h804, 32'h0);
      send(enc_jalr(5'd0, 5'd0), 1'b0, 32'h808, 32'h0);
      sb.push_back(e_push(32'h814));
      send(enc_jal(5'd5), 1'b0, 32'h810, 32'h0);
      sb.push_back(e_pop(32'h1000));
      sb.push_back(e_push(32'h884));
      send(enc_jalr(5'd1, 5'd5), 1'b0, 32'h880, 32'h1000);
      idle(4);
      chk("sb_drained", 32'(sb.size()), 32'h0);

      // Error with nothing issued and clear in RUN are both ignored
      ss_error = 1'b1;
      idle(3);
      ss_error = 1'b0;
      do_clear();
      @(negedge clk);
      chk("idle_err_alert", 32'(alert), 32'h0);
      chk("idle_err_ready", 32'(instr_ready), 32'h1);
      idle(1);

      // Return mismatch at pc 0x500
      sb.push_back(e_pop(32'h77));
      wait_ready();
      drive(enc_jalr(5'd0, 5'd1), 1'b0, 32'h500, 32'h77);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      ss_error = 1'b1;
      @(posedge clk);
      #1 ss_error = 1'b0;
      @(negedge clk);
      chk("mm_alert", 32'(alert), 32'h1);
      chk("mm_cause", 32'(fault_cause), 32'h2);
      chk("mm_fault_pc", fault_pc, 32'h500);
      chk("mm_ready", 32'(instr_ready), 32'h0);
      chk("mm_no_issue", 32'(ss_read), 32'h0);
      idle(2);
      chk("mm_held_pc", fault_pc, 32'h500);
      do_clear();
      @(negedge clk);
      chk("clr_alert", 32'(alert), 32'h0);
      chk("clr_cause", 32'(fault_cause), 32'h0);
      chk("clr_ready", 32'(instr_ready), 32'h1);
      idle(3);

      // Push overflow at pc 0x600
      sb.push_back(e_push(32'h604));
      wait_ready();
      drive(enc_jal(5'd1), 1'b0, 32'h600, 32'h0);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      ss_error = 1'b1;
      @(posedge clk);
      #1 ss_error = 1'b0;
      @(negedge clk);
      chk("ovf_cause", 32'(fault_cause), 32'h1);
      chk("ovf_fault_pc", fault_pc, 32'h600);
      idle(1);
      do_clear();
      idle(2);

      // Stall via fault: second swap call fills the queue, third is refused
      sb.push_back(e_pop(32'h900));
      sb.push_back(e_push(32'h904));
      wait_ready();
      drive(enc_jalr(5'd1, 5'd5), 1'b0, 32'h900, 32'h900);
      @(posedge clk);
      #1;
      chk("fill_ready_2nd", 32'(instr_ready), 32'h1);
      sb.push_back(e_pop(32'hA00));
      sb.push_back(e_push(32'hA04));
      drive(enc_jalr(5'd1, 5'd5), 1'b0, 32'hA00, 32'hA00);
      ss_error = 1'b1;
      @(posedge clk);
      #1 ss_error = 1'b0;
      drive(enc_jalr(5'd1, 5'd5), 1'b0, 32'hB00, 32'hB00);
      @(negedge clk);
      chk("fill_ready_drop", 32'(instr_ready), 32'h0);
      chk("fill_alert", 32'(alert), 32'h1);
      idle(3);
      instr_valid = 1'b0;
      chk("fill_ready_held", 32'(instr_ready), 32'h0);
      sb.delete();
      do_clear();
      @(negedge clk);
      chk("fill_clr_ready", 32'(instr_ready), 32'h1);
      chk("fill_clr_empty", 32'(ss_write | ss_read), 32'h0);
      idle(3);

      // Reset with three entries held in the queue
      sb.push_back(e_pop(32'hC00));
      sb.push_back(e_push(32'hC04));
      wait_ready();
      drive(enc_jalr(5'd1, 5'd5), 1'b0, 32'hC00, 32'hC00);
      @(posedge clk);
      #1;
      sb.push_back(e_push(32'hD04));
      drive(enc_jal(5'd1), 1'b0, 32'hD00, 32'h0);
      ss_error = 1'b1;
      @(posedge clk);
      #1 ss_error = 1'b0;
      instr_valid = 1'b0;
      chk("rst3_alert", 32'(alert), 32'h1);
      rst_n = 1'b0;
      sb.delete();
      idle(2);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst3_ready", 32'(instr_ready), 32'h1);
      chk("rst3_write", 32'(ss_write), 32'h0);
      chk("rst3_read", 32'(ss_read), 32'h0);
      chk("rst3_alert_clr", 32'(alert), 32'h0);
      idle(4);
      chk("rst3_quiet", 32'(ss_write | ss_read), 32'h0);
      chk("final_sb", 32'(sb.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
